// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
// Latency: n/a (declarations only).  Backpressure: n/a.
package div_pkg;

    localparam int DIV_W       = 4;
    localparam int DIV_LAT_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE
    } div_sched_state_t;

    localparam logic [DIV_W-1:0] DBZ_QUOT = {DIV_W{1'b1}};

    // Next round-robin start position after serving idx, modulo n.
    function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/div_sched_if.sv
// Requester and divider signals of the scheduler; master = environment, slave = scheduler.
// Latency: n/a (wires only).  Backpressure: req level held until ack.
interface div_sched_if #(
    parameter int NREQ = 2,
    parameter int W    = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      res_q;
    logic [W-1:0]      res_r;
    logic              res_dbz;
    logic              busy;
    logic              div_ld;
    logic [W-1:0]      div_a;
    logic [W-1:0]      div_b;
    logic [W-1:0]      div_ry;
    logic [2*W-1:0]    div_ra;

    modport master (
        output req, req_a, req_b, div_ry, div_ra,
        input  ack, res_q, res_r, res_dbz, busy, div_ld, div_a, div_b
    );

    modport slave (
        input  req, req_a, req_b, div_ry, div_ra,
        output ack, res_q, res_r, res_dbz, busy, div_ld, div_a, div_b
    );
endinterface

// File: rtl/div_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping modulo NREQ.
// Latency: combinational.  Backpressure: none; any=0 when nothing is requested.
module div_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   gnt_idx,
    output logic            any
);

    logic found;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        any     = |req;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found   = 1'b1;
                gnt_idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one shift-subtract divider; DIV_SCHED_DBZ_EN short-circuits zero divisors.
// Latency: ack DIV_LAT+2 cycles after the request is sampled (1 cycle for a short-circuited divide by zero).
// Backpressure: req is a held level; requests arriving while busy wait for the next IDLE and are never lost.
module div_sched
    import div_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = DIV_W,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input logic       clk,
    input logic       rst,
    div_sched_if.slave bus
);

    localparam int PW = 2;
    localparam int CW = $clog2(DIV_LAT + 1);

    div_sched_state_t state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    grant;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [NREQ-1:0]  ack_q;
    logic [W-1:0]     res_q_q;
    logic [W-1:0]     res_r_q;
    logic             res_dbz_q;
    logic             busy_q;
    logic             ld_q;

    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic             dbz_hit;

    div_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign sel_a = bus.req_a[int'(pick_idx)*W +: W];
    assign sel_b = bus.req_b[int'(pick_idx)*W +: W];

`ifdef DIV_SCHED_DBZ_EN
    assign dbz_hit = (sel_b == '0);
`else
    assign dbz_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            ack_q     <= '0;
            res_q_q   <= '0;
            res_r_q   <= '0;
            res_dbz_q <= 1'b0;
            busy_q    <= 1'b0;
            ld_q      <= 1'b0;
        end else begin
            ack_q <= '0;
            ld_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant  <= pick_idx;
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        busy_q <= 1'b1;
                        // Zero divisor bypasses the divider entirely; result is ready next cycle.
                        if (dbz_hit) begin
                            state     <= DONE;
                            ack_q     <= NREQ'(1) << pick_idx;
                            res_q_q   <= W'(DBZ_QUOT);
                            res_r_q   <= sel_a;
                            res_dbz_q <= 1'b1;
                        end else begin
                            state <= LOAD;
                            ld_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    cnt   <= CW'(DIV_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        ack_q     <= NREQ'(1) << grant;
                        res_q_q   <= bus.div_ry;
                        res_r_q   <= bus.div_ra[W-1:0];
                        res_dbz_q <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    ptr    <= wrap_inc(grant, NREQ);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.res_q   = res_q_q;
    assign bus.res_r   = res_r_q;
    assign bus.res_dbz = res_dbz_q;
    assign bus.busy    = busy_q;
    assign bus.div_ld  = ld_q;
    assign bus.div_a   = op_a;
    assign bus.div_b   = op_b;

endmodule
